multi_cycle_controller: RTL and testbench

Main sequencing FSM for the multi-cycle MIPS core. Sits directly downstream of the I-type and R-type opcode decoders: it drives their `active` enable during the decode cycle, samples their one-hot class flags, and steps the datapath through the fetch, decode, execute, memory and write-back phases. It also retires instructions into a counter and locks into a trap state on an illegal or ambiguous opcode.

---
 rtl/multi_cycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
//   Main sequencing FSM of the multi-cycle MIPS core. It enables the opcode
//   decoders during DECODE and samples their one-hot class flags. It steps the
//   datapath through fetch / decode / execute / memory / write-back, and
//   counts retired instructions. An illegal or ambiguous opcode locks the
//   FSM in TRAP until reset.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_ready           memory handshake, access completes when high
//   cond_true           branch comparison result (used in BRANCH only)
//   addi..jal, r_type   class flags from the I-type / R-type decoders
//   i_active            decoder enable (DECODE)
//   ir_write, pc_write  IR / PC load enables
//   pc_src              00 PC+4, 01 branch target, 10 jump target
//   mem_read/mem_write  memory strobes; mem_byte selects byte access
//   alu_src_b           00 rt, 01 sign-extended immediate
//   reg_write, reg_dst  register write enable; 00 rt, 01 rd, 10 $31
//   wb_sel              00 ALU, 01 memory, 10 PC+4
//   illegal             high in TRAP
//   retired             completed instruction count
//
// state   | meaning
// --------+---------------------------------------------
// FETCH   | read instruction, load IR and PC+4 on ready
// DECODE  | enable decoders, latch instruction class
// ADDR    | compute load/store address
// MEM_RD  | load data read, wait for ready
// MEM_WR  | store data write, wait for ready
// WB_MEM  | write loaded data to rt
// EXEC_I  | ALU op with immediate operand
// EXEC_R  | ALU op with register operand
// WB_ALU  | write ALU result to rt or rd
// BRANCH  | conditional PC load with branch target
// JUMP    | PC load with jump target, jal links $31
// TRAP    | illegal opcode, absorbing until reset

module multi_cycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic        cond_true,
  input  logic        addi,
  input  logic        addiu,
  input  logic        andi,
  input  logic        xori,
  input  logic        ori,
  input  logic        slti,
  input  logic        lui,
  input  logic        beq,
  input  logic        bne,
  input  logic        blez,
  input  logic        bgtz,
  input  logic        bgez,
  input  logic        lw,
  input  logic        lb,
  input  logic        sw,
  input  logic        sb,
  input  logic        r_type,
  input  logic        j,
  input  logic        jal,
  output logic        i_active,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  output logic [1:0]  alu_src_b,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH, DECODE, ADDR, MEM_RD, MEM_WR, WB_MEM,
    EXEC_I, EXEC_R, WB_ALU, BRANCH, JUMP, TRAP
  } state_t;

  state_t      state, state_nxt;
  logic        cls_load, cls_byte, cls_link, cls_rd;
  logic [31:0] retired_q;
  logic        retire;
  logic [18:0] flags;
  logic        is_mem, is_alu_i, is_branch, is_jump;

  assign flags = {addi, addiu, andi, xori, ori, slti, lui,
                  beq, bne, blez, bgtz, bgez,
                  lw, lb, sw, sb, r_type, j, jal};

  assign is_mem    = lw | lb | sw | sb;
  assign is_alu_i  = addi | addiu | andi | xori | ori | slti | lui;
  assign is_branch = beq | bne | blez | bgtz | bgez;
  assign is_jump   = j | jal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      cls_load  <= 1'b0;
      cls_byte  <= 1'b0;
      cls_link  <= 1'b0;
      cls_rd    <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        cls_load <= lw | lb;
        cls_byte <= lb | sb;
        cls_link <= jal;
        cls_rd   <= r_type;
      end
      if (retire)
        retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    unique case (state)
      FETCH:  if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        // exactly one class flag must be set; anything else is a trap
        if (!$onehot(flags))  state_nxt = TRAP;
        else if (is_mem)      state_nxt = ADDR;
        else if (is_alu_i)    state_nxt = EXEC_I;
        else if (r_type)      state_nxt = EXEC_R;
        else if (is_branch)   state_nxt = BRANCH;
        else if (is_jump)     state_nxt = JUMP;
        else                  state_nxt = TRAP;
      end
      ADDR:   state_nxt = cls_load ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) state_nxt = WB_MEM;
      MEM_WR: if (mem_ready) begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      WB_MEM, WB_ALU, BRANCH, JUMP: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      EXEC_I, EXEC_R: state_nxt = WB_ALU;
      TRAP:   state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
  end

  always_comb begin
    i_active  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_byte  = 1'b0;
    alu_src_b = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    illegal   = 1'b0;
    // reset blanks every output, even in the cycle before the state clears
    if (!rst) begin
      unique case (state)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: i_active = 1'b1;
        ADDR, EXEC_I: alu_src_b = 2'b01;
        MEM_RD: begin
          mem_read = 1'b1;
          mem_byte = cls_byte;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          mem_byte  = cls_byte;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 2'b01;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = cls_rd ? 2'b01 : 2'b00;
        end
        BRANCH: begin
          pc_src   = 2'b01;
          pc_write = cond_true;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          if (cls_link) begin
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wb_sel    = 2'b10;
          end
        end
        TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = rst ? 32'd0 : retired_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

  logic clk = 1'b0;
  logic rst, mem_ready, cond_true;
  logic addi, addiu, andi, xori, ori, slti, lui;
  logic beq, bne, blez, bgtz, bgez, lw, lb, sw, sb, r_type, j, jal;
  logic i_active, ir_write, pc_write, mem_read, mem_write, mem_byte;
  logic reg_write, illegal;
  logic [1:0] pc_src, alu_src_b, reg_dst, wb_sel;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .cond_true(cond_true),
    .addi(addi), .addiu(addiu), .andi(andi), .xori(xori), .ori(ori),
    .slti(slti), .lui(lui), .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz),
    .bgez(bgez), .lw(lw), .lb(lb), .sw(sw), .sb(sb), .r_type(r_type),
    .j(j), .jal(jal), .i_active(i_active), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte(mem_byte), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .illegal(illegal), .retired(retired)
  );

  // flag vector bit positions
  localparam logic [18:0] F_NONE = 19'd0;
  localparam logic [18:0] F_ADDI = 19'd1 << 18;
  localparam logic [18:0] F_BEQ  = 19'd1 << 11;
  localparam logic [18:0] F_BNE  = 19'd1 << 10;
  localparam logic [18:0] F_LW   = 19'd1 << 6;
  localparam logic [18:0] F_LB   = 19'd1 << 5;
  localparam logic [18:0] F_SB   = 19'd1 << 3;
  localparam logic [18:0] F_RT   = 19'd1 << 2;
  localparam logic [18:0] F_J    = 19'd1 << 1;
  localparam logic [18:0] F_JAL  = 19'd1;

  // expected output vector:
  // {i_active, ir_write, pc_write, pc_src[2], mem_read, mem_write, mem_byte,
  //  alu_src_b[2], reg_write, reg_dst[2], wb_sel[2], illegal}
  localparam logic [15:0] O_ZERO   = 16'h0000;
  localparam logic [15:0] O_FWAIT  = 16'h0400;
  localparam logic [15:0] O_FETCH  = 16'h6400;
  localparam logic [15:0] O_DEC    = 16'h8000;
  localparam logic [15:0] O_IMM    = 16'h0040;
  localparam logic [15:0] O_RDW    = 16'h0400;
  localparam logic [15:0] O_RDB    = 16'h0500;
  localparam logic [15:0] O_WRB    = 16'h0300;
  localparam logic [15:0] O_WBMEM  = 16'h0022;
  localparam logic [15:0] O_WBRT   = 16'h0020;
  localparam logic [15:0] O_WBRD   = 16'h0028;
  localparam logic [15:0] O_BRT    = 16'h2800;
  localparam logic [15:0] O_BRN    = 16'h0800;
  localparam logic [15:0] O_J      = 16'h3000;
  localparam logic [15:0] O_JAL    = 16'h3034;
  localparam logic [15:0] O_TRAP   = 16'h0001;

  typedef struct packed {
    logic [15:0] o;
    logic [31:0] r;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] obs_vec();
    return {i_active, ir_write, pc_write, pc_src, mem_read, mem_write,
            mem_byte, alu_src_b, reg_write, reg_dst, wb_sel, illegal};
  endfunction

  // One clock cycle: drive inputs after the falling edge, queue what the
  // outputs must be this cycle, sample 1 ns later, then wait for next fall.
  task automatic cyc(input logic r, input logic mr, input logic ct,
                     input logic [18:0] f, input logic [15:0] eo,
                     input logic [31:0] er, input string tag);
    exp_t e, got;
    rst = r; mem_ready = mr; cond_true = ct;
    {addi, addiu, andi, xori, ori, slti, lui, beq, bne, blez, bgtz, bgez,
     lw, lb, sw, sb, r_type, j, jal} = f;
    e.o = eo; e.r = er;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    checks++;
    assert (obs_vec() === got.o) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs_vec(), got.o);
    end
    checks++;
    assert (retired === got.r) else begin
      failures++;
      $error("FAIL %s retired observed=%h expected=%h", tag, retired, got.r);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; cond_true = 1'b0;
    {addi, addiu, andi, xori, ori, slti, lui, beq, bne, blez, bgtz, bgez,
     lw, lb, sw, sb, r_type, j, jal} = '0;
    @(negedge clk);

    cyc(1, 1, 1, F_LW, O_ZERO, 0, "reset0");
    cyc(1, 1, 0, F_NONE, O_ZERO, 0, "reset1");

    // lw, 5 cycles
    cyc(0, 1, 0, F_NONE, O_FETCH, 0, "lw_fetch");
    cyc(0, 1, 0, F_LW,   O_DEC,   0, "lw_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   0, "lw_addr");
    cyc(0, 1, 0, F_NONE, O_RDW,   0, "lw_memrd");
    cyc(0, 1, 0, F_NONE, O_WBMEM, 0, "lw_wbmem");

    // sb with 3 wait cycles in MEM_WR
    cyc(0, 1, 0, F_NONE, O_FETCH, 1, "sb_fetch");
    cyc(0, 1, 0, F_SB,   O_DEC,   1, "sb_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   1, "sb_addr");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, F_NONE, O_WRB, 1, "sb_memwr_wait");
    cyc(0, 1, 0, F_NONE, O_WRB,   1, "sb_memwr_done");

    // beq taken, bne not taken
    cyc(0, 1, 0, F_NONE, O_FETCH, 2, "beq_fetch");
    cyc(0, 1, 0, F_BEQ,  O_DEC,   2, "beq_decode");
    cyc(0, 1, 1, F_NONE, O_BRT,   2, "beq_branch");
    cyc(0, 1, 0, F_NONE, O_FETCH, 3, "bne_fetch");
    cyc(0, 1, 0, F_BNE,  O_DEC,   3, "bne_decode");
    cyc(0, 1, 0, F_NONE, O_BRN,   3, "bne_branch");

    // jal, then a stalled fetch
    cyc(0, 1, 0, F_NONE, O_FETCH, 4, "jal_fetch");
    cyc(0, 1, 0, F_JAL,  O_DEC,   4, "jal_decode");
    cyc(0, 1, 0, F_NONE, O_JAL,   4, "jal_jump");
    cyc(0, 0, 0, F_NONE, O_FWAIT, 5, "fetch_wait");

    // addi, r_type, j
    cyc(0, 1, 0, F_NONE, O_FETCH, 5, "addi_fetch");
    cyc(0, 1, 0, F_ADDI, O_DEC,   5, "addi_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   5, "addi_exec");
    cyc(0, 1, 0, F_NONE, O_WBRT,  5, "addi_wb");
    cyc(0, 1, 0, F_NONE, O_FETCH, 6, "rtype_fetch");
    cyc(0, 1, 0, F_RT,   O_DEC,   6, "rtype_decode");
    cyc(0, 1, 0, F_NONE, O_ZERO,  6, "rtype_exec");
    cyc(0, 1, 0, F_NONE, O_WBRD,  6, "rtype_wb");
    cyc(0, 1, 0, F_NONE, O_FETCH, 7, "j_fetch");
    cyc(0, 1, 0, F_J,    O_DEC,   7, "j_decode");
    cyc(0, 1, 0, F_NONE, O_J,     7, "j_jump");

    // no flags -> TRAP, absorbing
    cyc(0, 1, 0, F_NONE, O_FETCH, 8, "trap0_fetch");
    cyc(0, 1, 0, F_NONE, O_DEC,   8, "trap0_decode");
    for (int i = 0; i < 11; i++)
      cyc(0, 1, 1, (i % 2 == 0) ? F_LW : F_JAL, O_TRAP, 8, "trap0_hold");
    cyc(1, 1, 0, F_NONE, O_ZERO,  0, "trap0_rst");
    cyc(0, 1, 0, F_NONE, O_FETCH, 0, "trap0_refetch");

    // two flags -> TRAP
    cyc(0, 1, 0, F_ADDI | F_LW, O_DEC, 0, "trap1_decode");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, F_NONE, O_TRAP, 0, "trap1_hold");
    cyc(1, 0, 0, F_NONE, O_ZERO,  0, "trap1_rst");

    // counter wrap: preset retired to all-ones during a stalled fetch
    force dut.retired_q = 32'hFFFF_FFFF;
    cyc(0, 0, 0, F_NONE, O_FWAIT, 32'hFFFF_FFFF, "wrap_preset");
    release dut.retired_q;
    cyc(0, 1, 0, F_NONE, O_FETCH, 32'hFFFF_FFFF, "wrap_fetch");
    cyc(0, 1, 0, F_ADDI, O_DEC,   32'hFFFF_FFFF, "wrap_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   32'hFFFF_FFFF, "wrap_exec");
    cyc(0, 1, 0, F_NONE, O_WBRT,  32'hFFFF_FFFF, "wrap_wb");
    cyc(0, 1, 0, F_NONE, O_FETCH, 32'd0,         "wrap_done");

    // reset in the middle of a byte load wait
    cyc(0, 1, 0, F_LB,   O_DEC,   0, "abort_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   0, "abort_addr");
    cyc(0, 0, 0, F_NONE, O_RDB,   0, "abort_memrd");
    cyc(1, 1, 0, F_NONE, O_ZERO,  0, "abort_rst");
    cyc(0, 0, 0, F_NONE, O_FWAIT, 0, "abort_refetch");

    // reset during a store wait: no write strobe afterwards
    cyc(0, 1, 0, F_NONE, O_FETCH, 0, "abort2_fetch");
    cyc(0, 1, 0, F_SB,   O_DEC,   0, "abort2_decode");
    cyc(0, 1, 0, F_NONE, O_IMM,   0, "abort2_addr");
    cyc(0, 0, 0, F_NONE, O_WRB,   0, "abort2_memwr");
    cyc(1, 0, 0, F_NONE, O_ZERO,  0, "abort2_rst");
    cyc(0, 0, 0, F_NONE, O_FWAIT, 0, "abort2_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
